// File: rtl/sumador_pkg.sv
// Shared types and constants for the nibble-serial add/subtract sequencer.
package sumador_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIN
  } estado_t;

  localparam int unsigned NIBBLE_W = 4;
  localparam logic        OP_SUMA  = 1'b0;
  localparam logic        OP_RESTA = 1'b1;

endpackage

// File: rtl/sumador_4b.sv
// Purely combinational 4-bit adder slice with carry in/out.
module sumador_4b
  import sumador_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] y,
  output logic                cout
);

  logic [NIBBLE_W:0] w_full;

  assign w_full    = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, cin};
  assign {cout, y} = w_full;

endmodule

// File: rtl/sumador_serie_ctrl.sv
// Nibble-serial wide add/subtract sequencer around one 4-bit slice.
// Optional signed-overflow output enabled by SUMADOR_SERIE_OVERFLOW_EN.
module sumador_serie_ctrl
  import sumador_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    op,
  input  logic [4*NIBBLES-1:0]    a,
  input  logic [4*NIBBLES-1:0]    b,
  output logic                    busy,
  output logic                    done,
  output logic [4*NIBBLES-1:0]    y,
  output logic                    cout
`ifdef SUMADOR_SERIE_OVERFLOW_EN
  ,
  output logic                    ovf
`endif
);

  localparam int unsigned W        = NIBBLES * NIBBLE_W;
  localparam int unsigned CNT_W    = $clog2(NIBBLES + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

  estado_t            r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_carry;
  logic               r_op;
  logic [W-1:0]       r_a;
  logic [W-1:0]       r_b;
  // Only the upper W-4 bits are kept; the newest nibble joins them on the fly.
  logic [W-NIBBLE_W-1:0] r_res;
  logic               r_busy;
  logic               r_done;
  logic [W-1:0]       r_y;
  logic               r_cout;
`ifdef SUMADOR_SERIE_OVERFLOW_EN
  logic               r_sa;
  logic               r_sbp;
  logic               r_ovf;
`endif

  logic [NIBBLE_W-1:0] w_b_nib;
  logic [NIBBLE_W-1:0] w_sum;
  logic                w_cout;
  logic [W-1:0]        w_res_next;

  // Subtract is a + ~b + 1; the +1 was preloaded into r_carry at start.
  assign w_b_nib    = (r_op == OP_RESTA) ? ~r_b[NIBBLE_W-1:0] : r_b[NIBBLE_W-1:0];
  assign w_res_next = {w_sum, r_res};

  sumador_4b u_slice (
    .a    (r_a[NIBBLE_W-1:0]),
    .b    (w_b_nib),
    .cin  (r_carry),
    .y    (w_sum),
    .cout (w_cout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_op    <= OP_SUMA;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_y     <= '0;
      r_cout  <= 1'b0;
`ifdef SUMADOR_SERIE_OVERFLOW_EN
      r_sa    <= 1'b0;
      r_sbp   <= 1'b0;
      r_ovf   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_op    <= op;
            r_carry <= op;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= CALC;
`ifdef SUMADOR_SERIE_OVERFLOW_EN
            r_sa    <= a[W-1];
            r_sbp   <= op ? ~b[W-1] : b[W-1];
`endif
          end
        end
        CALC: begin
          r_a     <= r_a >> NIBBLE_W;
          r_b     <= r_b >> NIBBLE_W;
          r_res   <= w_res_next[W-1:NIBBLE_W];
          r_carry <= w_cout;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_CNT) begin
            r_y     <= w_res_next;
            r_cout  <= w_cout;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= FIN;
`ifdef SUMADOR_SERIE_OVERFLOW_EN
            r_ovf   <= (r_sa == r_sbp) & (w_res_next[W-1] != r_sa);
`endif
          end
        end
        FIN: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign y    = r_y;
  assign cout = r_cout;
`ifdef SUMADOR_SERIE_OVERFLOW_EN
  assign ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_sumador_serie_ctrl.sv
// Scoreboard bench for sumador_serie_ctrl (NIBBLES=4); checks ovf when
// SUMADOR_SERIE_OVERFLOW_EN is defined.
module tb_sumador_serie_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        op;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] y;
  logic        cout;
`ifdef SUMADOR_SERIE_OVERFLOW_EN
  logic        ovf;
`endif

  always #5 clk = ~clk;

  sumador_serie_ctrl #(
    .NIBBLES (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .y     (y),
    .cout  (cout)
`ifdef SUMADOR_SERIE_OVERFLOW_EN
    ,
    .ovf   (ovf)
`endif
  );

  typedef struct packed {
    logic [15:0] y;
    logic        cout;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("done_without_request", {31'd0, done}, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("y", {16'd0, y}, {16'd0, e.y});
          chk("cout", {31'd0, cout}, {31'd0, e.cout});
`ifdef SUMADOR_SERIE_OVERFLOW_EN
          chk("ovf", {31'd0, ovf}, {31'd0, e.ovf});
`endif
        end
      end
    end
  end

  // Issue one operation from IDLE and check busy/done timing; ends at edge k+5 +1.
  task automatic do_op(input logic [15:0] a_i, input logic [15:0] b_i, input logic op_i,
                       input logic [15:0] y_e, input logic cout_e, input logic ovf_e);
    exp_t e;
    e.y    = y_e;
    e.cout = cout_e;
    e.ovf  = ovf_e;
    exp_q.push_back(e);
    a     = a_i;
    b     = b_i;
    op    = op_i;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a     = ~a_i;
    b     = ~b_i;
    op    = ~op_i;
    chk("busy_k", {31'd0, busy}, 32'd1);
    chk("done_k", {31'd0, done}, 32'd0);
    for (int i = 1; i < 4; i++) begin
      @(posedge clk); #1;
      chk("busy_calc", {31'd0, busy}, 32'd1);
      chk("done_calc", {31'd0, done}, 32'd0);
    end
    @(posedge clk); #1;
    chk("busy_fin", {31'd0, busy}, 32'd0);
    chk("done_fin", {31'd0, done}, 32'd1);
    @(posedge clk); #1;
    chk("done_after_fin", {31'd0, done}, 32'd0);
    chk("busy_after_fin", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    op    = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_y", {16'd0, y}, 32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    do_op(16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    do_op(16'h1000, 16'h0001, 1'b1, 16'h0FFF, 1'b1, 1'b0);
    do_op(16'h0001, 16'h0002, 1'b1, 16'hFFFF, 1'b0, 1'b0);

    // Start held high, operands changed mid-CALC; second op starts at edge k+6.
    exp_q.push_back('{y: 16'h0007, cout: 1'b0, ovf: 1'b0});
    exp_q.push_back('{y: 16'h0120, cout: 1'b0, ovf: 1'b0});
    a     = 16'h0003;
    b     = 16'h0004;
    op    = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    chk("hold_busy_k", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    a = 16'h0100;
    b = 16'h0020;
    repeat (2) @(posedge clk);
    @(posedge clk); #1;
    chk("hold_done_k4", {31'd0, done}, 32'd1);
    @(posedge clk); #1;
    chk("hold_busy_k5", {31'd0, busy}, 32'd0);
    chk("hold_done_k5", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    chk("hold_busy_k6", {31'd0, busy}, 32'd1);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("hold_done_k10", {31'd0, done}, 32'd1);
    @(posedge clk); #1;
    chk("hold_done_k11", {31'd0, done}, 32'd0);

    // Reset during the second CALC cycle aborts with no done.
    a     = 16'h1111;
    b     = 16'h2222;
    op    = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_y", {16'd0, y}, 32'd0);
    chk("abort_cout", {31'd0, cout}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("abort_no_done", {31'd0, done}, 32'd0);
    end
    do_op(16'h0002, 16'h0003, 1'b0, 16'h0005, 1'b0, 1'b0);

    // Signed-overflow vectors; ovf compared only when the port exists.
    do_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    do_op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    do_op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
